// File: rtl/event_encoder_eight.sv
// Sequential 8-to-3 encoder: synchronizes request lines, queues edge events
// and hands out their binary indices lowest-first over valid/ready.
module event_encoder_eight #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_MODE   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_req,
    output logic [2:0] out_idx,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] pending,
    output logic       overflow,
    input  logic       clr_ovf
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0][7:0] sync_q;
    logic [7:0] sync_s;
    logic [7:0] prev;
    logic [7:0] rise;
    logic [7:0] take;
    logic [7:0] lost;
    logic [7:0] low_hot;
    logic [2:0] low_idx;
    logic       load;
    logic       ovf_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev   <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_req};
            prev   <= sync_s;
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];
    assign rise   = EDGE_MODE ? (sync_s & ~prev) : sync_s;

    // Scan downward so the last hit is the lowest set bit
    always_comb begin
        low_idx = '0;
        low_hot = '0;
        for (int i = 7; i >= 0; i--) begin
            if (pending[i]) begin
                low_idx = 3'(i);
                low_hot = 8'd1 << i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        take    = '0;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (|pending) begin
                    take    = low_hot;
                    load    = 1'b1;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (|pending) begin
                        take = low_hot;
                        load = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign out_valid = (state == HOLD);

    // A rise on a bit being taken this cycle re-queues it and is not a loss
    assign lost    = rise & pending & ~take;
    assign ovf_set = EDGE_MODE && (|lost);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= '0;
            out_idx  <= '0;
            overflow <= 1'b0;
        end else begin
            pending <= (pending & ~take) | rise;
            if (load) begin
                out_idx <= low_idx;
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_event_encoder_eight.sv
// Scoreboard bench for event_encoder_eight: a per-cycle reference model
// predicts status and transfers; a negedge monitor compares.
module tb_event_encoder_eight;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_req = '0;
    logic       out_ready = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [2:0] out_idx;
    logic       out_valid;
    logic [7:0] pending;
    logic       overflow;

    always #5 clk = ~clk;

    event_encoder_eight #(
        .SYNC_STAGES(SYNC),
        .EDGE_MODE  (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_req   (in_req),
        .out_idx  (out_idx),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .pending  (pending),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    typedef struct packed {
        logic       v;
        logic [2:0] idx;
        logic [7:0] pend;
        logic       ovf;
    } snap_t;

    snap_t      snap_q[$];
    logic [2:0] xfer_q[$];

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [7:0] m_sync[SYNC];
    logic [7:0] m_prev;
    logic [7:0] m_pend;
    int         m_slot;
    bit         m_ovf;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < SYNC; j++) m_sync[j] = '0;
        m_prev = '0;
        m_pend = '0;
        m_slot = -1;
        m_ovf  = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] req, input bit rdy,
                              input bit clr);
        logic [7:0] s;
        logic [7:0] rise;
        logic [7:0] take;
        int         pick;
        s    = m_sync[SYNC-1];
        rise = s & ~m_prev;
        take = '0;
        // Output slot frees when empty or accepted; refill from lowest pending
        if (m_slot < 0 || rdy) begin
            pick = lowest(m_pend);
            if (pick >= 0) take[pick] = 1'b1;
            m_slot = pick;
        end
        if ((rise & m_pend & ~take) != 0) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_pend = (m_pend & ~take) | rise;
        m_prev = s;
        for (int j = SYNC - 1; j > 0; j--) m_sync[j] = m_sync[j-1];
        m_sync[0] = req;
    endtask

    task automatic cycle(input logic [7:0] req, input bit rdy, input bit clr);
        snap_t e;
        in_req    = req;
        out_ready = rdy;
        clr_ovf   = clr;
        e.v    = (m_slot >= 0);
        e.idx  = 3'(m_slot);
        e.pend = m_pend;
        e.ovf  = m_ovf;
        snap_q.push_back(e);
        if (m_slot >= 0 && rdy) xfer_q.push_back(3'(m_slot));
        @(posedge clk);
        model_step(req, rdy, clr);
        #1;
    endtask

    always @(negedge clk) begin
        snap_t      e;
        logic [2:0] x;
        if (!rst) begin
            if (snap_q.size() > 0) begin
                e = snap_q.pop_front();
                chk("out_valid", 32'(out_valid), 32'(e.v));
                chk("pending", 32'(pending), 32'(e.pend));
                chk("overflow", 32'(overflow), 32'(e.ovf));
                if (e.v) chk("out_idx", 32'(out_idx), 32'(e.idx));
            end
            if (out_valid && out_ready) begin
                if (xfer_q.size() == 0) begin
                    chk("unexpected_xfer", 32'(out_idx), 32'hFF);
                end else begin
                    x = xfer_q.pop_front();
                    chk("xfer_idx", 32'(out_idx), 32'(x));
                end
            end
        end
    end

    logic [7:0] rq;

    initial begin
        model_reset();
        in_req = 8'h40;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Line held high through reset release: one event on index 6
        repeat (4) cycle(8'h40, 1'b1, 1'b0);
        repeat (4) cycle(8'h00, 1'b1, 1'b0);

        // Single pulse on bit 5
        repeat (3) cycle(8'h20, 1'b1, 1'b0);
        repeat (6) cycle(8'h00, 1'b1, 1'b0);

        // Multi-bit burst: indices 0, 4, 7 back to back
        repeat (3) cycle(8'h91, 1'b1, 1'b0);
        repeat (6) cycle(8'h00, 1'b1, 1'b0);

        // Repeated edges on bit 3 without acceptance, then clear
        repeat (3) cycle(8'h08, 1'b0, 1'b0);
        repeat (3) cycle(8'h00, 1'b0, 1'b0);
        repeat (3) cycle(8'h08, 1'b0, 1'b0);
        repeat (3) cycle(8'h00, 1'b0, 1'b0);
        repeat (3) cycle(8'h08, 1'b0, 1'b0);
        repeat (2) cycle(8'h00, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b1);
        repeat (2) cycle(8'h00, 1'b0, 1'b0);
        repeat (6) cycle(8'h00, 1'b1, 1'b0);

        // Long stall on bit 2
        repeat (2) cycle(8'h04, 1'b0, 1'b0);
        repeat (10) cycle(8'h00, 1'b0, 1'b0);
        repeat (4) cycle(8'h00, 1'b1, 1'b0);

        // New rise on bit 1 in the same cycle bit 1 is taken
        cycle(8'h03, 1'b1, 1'b0);
        cycle(8'h01, 1'b1, 1'b0);
        cycle(8'h03, 1'b1, 1'b0);
        repeat (8) cycle(8'h00, 1'b1, 1'b0);

        // Reset while presenting with pending bits 6 and 7 queued
        repeat (3) cycle(8'h01, 1'b0, 1'b0);
        repeat (5) cycle(8'hC1, 1'b0, 1'b0);
        chk("pre_rst_pending", 32'(pending), 32'hC0);
        chk("pre_rst_valid", 32'(out_valid), 32'h1);
        rst = 1'b1;
        in_req = 8'h00;
        #1;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        snap_q.delete();
        xfer_q.delete();
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) cycle(8'h00, 1'b1, 1'b0);

        // Randomized traffic
        rq = '0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 2) == 0) rq = rq ^ (8'($urandom) & 8'($urandom));
            cycle(rq, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end
        repeat (20) cycle(8'h00, 1'b1, 1'b0);

        @(negedge clk);
        #1;
        chk("xfer_q_empty", 32'(xfer_q.size()), 32'h0);
        chk("snap_q_empty", 32'(snap_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/event_encoder_eight.md
Name: event_encoder_eight

Overview:
- Sequential 8-to-3 encoder: the return path for the team's 3-to-8 one-hot decoders.
- Watches 8 asynchronous request lines and detects rising edges.
- Queues each event as a pending bit.
- Emits one 3-bit binary index per event over a valid/ready handshake, lowest index first.
- Sits between board inputs (buttons, decoder-driven strobes) and downstream logic that consumes binary codes.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on in_req (legal 2..4).
- EDGE_MODE, 1: 1 = an event is a rising edge of the synchronized input; 0 = level mode, where a high synchronized input re-sets its pending bit every cycle.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- in_req  input  8  asynchronous request lines; bit k maps to index k.
- out_idx  output  3  binary index of the presented event.
- out_valid  output  1  out_idx holds an unconsumed event.
- out_ready  input  1  consumer accepts out_idx this cycle when out_valid=1.
- pending  output  8  queued events not yet presented.
- overflow  output  1  sticky flag: an event was lost.
- clr_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async assert, sync release): all synchronizer flops, prev register, pending, out_idx, out_valid and overflow go to 0; the FSM goes to IDLE.
- A line held high through reset release yields exactly one event in EDGE_MODE=1.
- Synchronizer: SYNC_STAGES flops per bit; s = last stage.
- Edge detect: prev <= s every cycle; rise = s & ~prev (EDGE_MODE=1) or rise = s (EDGE_MODE=0).
- Pending update: pending <= (pending & ~take) | rise, where take is the one-hot bit moved to the output stage this cycle.
- Set wins over take on the same bit: a new event arriving as the old one is presented stays queued, with no overflow.
- Overflow: set when rise[k]=1 and pending[k]=1 and take[k]=0; pending[k] stays 1.
  - Overflow is never set in EDGE_MODE=0.
  - clr_ovf clears overflow; if set and clear occur in the same cycle, set wins.
- Priority: take = lowest set bit of the registered pending (bit 0 highest priority); out_idx = its binary index. Bits arriving this cycle are not eligible until the next cycle.
- FSM IDLE (out_valid=0):
  - If pending != 0, load out_idx, assert out_valid and assert take; go to HOLD.
  - Otherwise stay.
- FSM HOLD (out_valid=1):
  - out_idx is stable while out_ready=0.
  - On out_ready=1 with pending != 0: load the next lowest index and assert take; out_valid stays 1. This gives back-to-back transfers, one per cycle.
  - On out_ready=1 with pending == 0: out_valid <= 0; go to IDLE.
- out_ready while out_valid=0 is ignored.
- Latency at SYNC_STAGES=2: in_req[k] first sampled high at edge t0 gives pending[k]=1 after t2, and out_valid=1 with out_idx=k after t3. Throughput is 1 event/cycle.
- All outputs are registered; no combinational path from in_req or out_ready to any output.
- Mid-operation reset: an in-flight event and all pending bits are discarded, and out_valid drops immediately on rst assertion.

Test Plan:
- Reset, then pulse in_req=8'h20 for 3 cycles with out_ready=1 -> out_valid high for 1 cycle, 3 edges after first sample, with out_idx=3'd5; pending returns to 0; overflow=0.
- in_req 8'h00->8'h91 in one cycle, out_ready=1 -> out_idx sequence 0, 4, 7 on consecutive cycles; out_valid then 0.
- out_ready=0; event on bit 3, then release and re-raise bit 3 -> out_idx=3 held and pending=8'h08 after the second edge, overflow=0. A third edge on bit 3 before acceptance -> overflow=1. Then clr_ovf=1 for 1 cycle -> overflow=0.
- Handshake stall: event on bit 2 with out_ready=0 for 10 cycles -> out_idx=2 and out_valid=1 stable throughout; accept -> out_valid=0 next cycle.
- Same-cycle take/set: bit 1 pending and being taken while a new rise on bit 1 arrives -> pending[1] stays 1, overflow=0, and a second out_idx=1 is presented.
- Assert rst while out_valid=1 and pending=8'hC0 -> out_valid, pending and overflow are 0 asynchronously; no events after release with in_req=0.
